accum_sequencer: RTL and testbench

ACCUM_SEQUENCER -- requirements
Module: accum_sequencer

---
 rtl/accum_sequencer.sv | 114 +++++++++++
 tb/tb_accum_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_sequencer.sv
// ============================================================================
// Module   : accum_sequencer
// Purpose  : Accumulates a start-requested run of 8-bit operands with a sticky carry flag.
//            Define ACCUM_SATURATE_EN to clamp at 8'hFF instead of wrapping modulo 256.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_sequencer #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_sum,
    output logic             out_cout,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_cnt_one = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [7:0]       acc_q;
    logic [7:0]       acc_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             cout_q;
    logic             out_valid_q;
    logic [8:0]       sum_w;
    logic             carry_w;

    always_comb begin
        sum_w   = {1'b0, acc_q} + {1'b0, in_data};
        carry_w = sum_w[8];
        cnt_d   = cnt_q + c_cnt_one;
`ifdef ACCUM_SATURATE_EN
        // Once any carry has been seen the accumulator is pinned at full scale.
        acc_d   = (carry_w || cout_q) ? 8'hFF : sum_w[7:0];
`else
        acc_d   = sum_w[7:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            len_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= 8'h00;
                        cnt_q  <= '0;
                        cout_q <= 1'b0;
                        len_q  <= len;
                        if (len == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q  <= acc_d;
                        cnt_q  <= cnt_d;
                        cout_q <= cout_q | carry_w;
                        if (cnt_d == len_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_sequencer.sv
// ============================================================================
// Module   : tb_accum_sequencer
// Purpose  : Directed self-checking bench for accum_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_ready;
    logic       busy;

    int checks;
    int failures;

    accum_sequencer #(.LEN_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_seq(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_op(input logic [7:0] d, input int gaps);
        in_valid = 1'b0;
        for (int g = 0; g < gaps; g++) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, in_ready, out_valid, out_cout, out_sum} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b vld=%b cout=%b sum=%0d, want all 0",
                     busy, in_ready, out_valid, out_cout, out_sum);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b vld=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        begin_seq(4'd3);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_accum_entry: got rdy=%b busy=%b, want 1 1", in_ready, busy);
        end
        send_op(8'd10, 0);
        send_op(8'd20, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got vld=%b, want 0", out_valid);
        end
        send_op(8'd30, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd60 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got vld=%b sum=%0d cout=%b rdy=%b, want 1 60 0 0",
                     out_valid, out_sum, out_cout, in_ready);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle: got vld=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_carry();
        logic [7:0] exp_sum;
`ifdef ACCUM_SATURATE_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd44;
`endif
        begin_seq(4'd2);
        send_op(8'd200, 0);
        send_op(8'd100, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== exp_sum || out_cout !== 1'b1) begin
            failures++;
            $display("FAIL carry_result: got vld=%b sum=%0d cout=%b, want 1 %0d 1",
                     out_valid, out_sum, out_cout, exp_sum);
        end
        handshake();
    endtask

    task automatic test_gaps_stall();
        begin_seq(4'd4);
        send_op(8'd1, 0);
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'd1) begin
            failures++;
            $display("FAIL gap_stall: got rdy=%b vld=%b sum=%0d, want 1 0 1", in_ready, out_valid, out_sum);
        end
        send_op(8'd2, 0);
        send_op(8'd3, 2);
        send_op(8'd4, 2);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL gap_done: got vld=%b, want 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'd10 || out_cout !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold_%0d: got vld=%b sum=%0d cout=%b, want 1 10 0",
                         i, out_valid, out_sum, out_cout);
            end
            tick();
        end
        handshake();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle: got busy=%b vld=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_start_ignored();
        begin_seq(4'd3);
        start = 1'b1;
        len   = 4'd7;
        tick();
        start = 1'b0;
        len   = 4'd0;
        send_op(8'd1, 0);
        send_op(8'd1, 0);
        send_op(8'd1, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd3) begin
            failures++;
            $display("FAIL start_ignored_accum: got vld=%b sum=%0d, want 1 3", out_valid, out_sum);
        end
        start = 1'b1;
        len   = 4'd2;
        tick();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd3) begin
            failures++;
            $display("FAIL start_ignored_done: got vld=%b sum=%0d, want 1 3", out_valid, out_sum);
        end
        handshake();
        begin_seq(4'd0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd0 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL len_zero: got vld=%b sum=%0d cout=%b rdy=%b, want 1 0 0 0",
                     out_valid, out_sum, out_cout, in_ready);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        begin_seq(4'd3);
        send_op(8'd50, 0);
        send_op(8'd60, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, out_valid, out_cout, out_sum} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_async: got busy=%b rdy=%b vld=%b cout=%b sum=%0d, want all 0",
                     busy, in_ready, out_valid, out_cout, out_sum);
        end
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet_%0d: got vld=%b busy=%b, want 0 0", i, out_valid, busy);
            end
        end
        in_valid = 1'b0;
        begin_seq(4'd1);
        send_op(8'd5, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_cout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_new_seq: got vld=%b sum=%0d cout=%b, want 1 5 0",
                     out_valid, out_sum, out_cout);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        begin_seq(4'd2);
        send_op(8'd7, 0);
        send_op(8'd8, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd15) begin
            failures++;
            $display("FAIL b2b_first: got vld=%b sum=%0d, want 1 15", out_valid, out_sum);
        end
        handshake();
        begin_seq(4'd1);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start_accepted: got rdy=%b, want 1", in_ready);
        end
        send_op(8'd9, 0);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd9 || out_cout !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got vld=%b sum=%0d cout=%b, want 1 9 0",
                     out_valid, out_sum, out_cout);
        end
        handshake();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_gaps_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
